step_timer_ctrl: RTL and testbench

//   Schedules execution ticks for the LED CPU from one programmable interval counter.

---
 rtl/timer_pkg.sv | 20 ++
 rtl/step_timer_ctrl_rise_detect.sv | 33 +++
 rtl/step_timer_ctrl.sv | 172 +++++++++++++++++
 tb/tb_step_timer_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the step/run/halt tick scheduler.
//   - state_e     : FSM state encodings driven onto the 2-bit state port
//   - DEF_CNT_WDTH: default width of the interval counter and period registers
//   - is_active() : true for the states that advance the interval counter
package timer_pkg;

    localparam int unsigned DEF_CNT_WDTH = 32'd30;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    // RUN and STEP both count toward a tick; HALT and the unused code do not.
    function automatic logic is_active(input logic [1:0] st);
        is_active = (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/step_timer_ctrl_rise_detect.sv
// Rising-edge detector for the raw step request.
// Ports:
//   mclk : system clock (posedge)
//   rst  : synchronous active-low reset, clears the history flop
//   in   : level input
//   rise : in & ~previous-cycle in (combinational from the history flop)
module rise_detect (
    input  logic mclk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // Next value of the history flop.
    always_comb begin
        prev_d = in;
    end

    // One-cycle history of the input.
    always_ff @(posedge mclk) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = in & ~prev_q;

endmodule

// File: rtl/step_timer_ctrl.sv
// Tick scheduler for the LED CPU: one programmable interval counter drives a
// one-cycle clock-enable pulse in RUN (free-running) or STEP (single tick) mode.
// Optional feature macro: TICK_CNT_EN (implements the tick_cnt counter; when
// undefined tick_cnt is tied to zero and no counter flops exist).
// Ports:
//   mclk       : system clock, all logic on posedge
//   rst        : synchronous active-low reset
//   cfg_we     : write cfg_period into the pending-period register
//   cfg_period : new interval period (interval = period+1 cycles)
//   run        : level, request RUN
//   halt       : level, force HALT (highest priority)
//   step_req   : raw step request, rising edge starts one STEP
//   tick       : registered one-cycle CPU enable
//   busy       : registered, 1 while in RUN or STEP
//   state      : current FSM state encoding
//   tick_cnt   : ticks issued since reset, wrapping
module step_timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CNT_WDTH   = DEF_CNT_WDTH,
    parameter int unsigned DEF_PERIOD = 32'd1,
    parameter int unsigned TCNT_WDTH  = 32'd16
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [CNT_WDTH-1:0]  cfg_period,
    input  logic                 run,
    input  logic                 halt,
    input  logic                 step_req,
    output logic                 tick,
    output logic                 busy,
    output logic [1:0]           state,
    output logic [TCNT_WDTH-1:0] tick_cnt
);

    localparam logic [CNT_WDTH-1:0] RST_PERIOD = CNT_WDTH'(DEF_PERIOD);

    logic                step_rise_s;
    logic                at_end_s;
    logic                entry_s;
    state_e              state_q, state_d;
    logic [CNT_WDTH-1:0] count_q, count_d;
    logic [CNT_WDTH-1:0] period_q, period_d;
    logic [CNT_WDTH-1:0] pend_q, pend_d;
    logic                tick_q, tick_d;
    logic                busy_q, busy_d;

    rise_detect u_step_rise (
        .mclk (mclk),
        .rst  (rst),
        .in   (step_req),
        .rise (step_rise_s)
    );

    // Next-state, counter, period and output logic.
    always_comb begin
        state_d  = state_q;
        at_end_s = is_active(state_q) && (count_q == period_q);

        case (state_q)
            ST_HALT: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (run) begin
                    state_d = ST_RUN;       // run beats a simultaneous step edge
                end else if (step_rise_s) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_RUN: begin
                if (halt || !run) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                // Step edges seen here are dropped: the detector keeps no queue.
                if (halt || at_end_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        entry_s = (state_d != state_q);

        // Counter restarts on any state change and at the end of each interval.
        if (entry_s || at_end_s) begin
            count_d = {CNT_WDTH{1'b0}};
        end else if (is_active(state_q)) begin
            count_d = count_q + CNT_WDTH'(1);
        end else begin
            count_d = {CNT_WDTH{1'b0}};
        end

        if (cfg_we) begin
            pend_d = cfg_period;
        end else begin
            pend_d = pend_q;
        end

        // Period only changes at interval boundaries, and always from the
        // already-registered pending value, so a write landing on a tick
        // cycle takes effect one interval later.
        if ((entry_s && is_active(state_d)) || at_end_s) begin
            period_d = pend_q;
        end else begin
            period_d = period_q;
        end

        tick_d = at_end_s && !halt;
        busy_d = is_active(state_d);
    end

    // Main state register.
    always_ff @(posedge mclk) begin
        if (!rst) begin
            state_q  <= ST_HALT;
            count_q  <= {CNT_WDTH{1'b0}};
            period_q <= RST_PERIOD;
            pend_q   <= RST_PERIOD;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            busy_q   <= busy_d;
        end
    end

    assign tick  = tick_q;
    assign busy  = busy_q;
    assign state = state_q;

`ifdef TICK_CNT_EN
    logic [TCNT_WDTH-1:0] tcnt_q, tcnt_d;

    // Count on the same edge that raises tick so the count and pulse align.
    always_comb begin
        if (tick_d) begin
            tcnt_d = tcnt_q + TCNT_WDTH'(1);
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    // Tick counter register.
    always_ff @(posedge mclk) begin
        if (!rst) begin
            tcnt_q <= {TCNT_WDTH{1'b0}};
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign tick_cnt = tcnt_q;
`else
    assign tick_cnt = {TCNT_WDTH{1'b0}};
`endif

endmodule

// File: tb/tb_step_timer_ctrl.sv
// Directed self-checking bench for step_timer_ctrl (default parameters:
// CNT_WDTH=30, DEF_PERIOD=1, TCNT_WDTH=16). Inputs are driven and outputs
// sampled 1 time unit after each rising edge; "edge k" below means the k-th
// rising edge after the stimulus that starts a scenario.
module tb_step_timer_ctrl;

    logic        mclk;
    logic        rst;
    logic        cfg_we;
    logic [29:0] cfg_period;
    logic        run;
    logic        halt;
    logic        step_req;
    logic        tick;
    logic        busy;
    logic [1:0]  state;
    logic [15:0] tick_cnt;

    int n_cmp;
    int n_err;

    step_timer_ctrl dut (
        .mclk       (mclk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_period (cfg_period),
        .run        (run),
        .halt       (halt),
        .step_req   (step_req),
        .tick       (tick),
        .busy       (busy),
        .state      (state),
        .tick_cnt   (tick_cnt)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic clk();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected tick_cnt after n ticks since reset.
    function automatic logic [31:0] ecnt(input int n);
`ifdef TICK_CNT_EN
        ecnt = 32'(n) & 32'h0000_FFFF;
`else
        ecnt = 32'd0;
`endif
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0; cfg_we = 1'b0; cfg_period = 30'd0;
        run = 1'b0; halt = 1'b0; step_req = 1'b0;
        repeat (3) clk();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tcnt", 32'(tick_cnt), 32'd0);

        // 1: RUN with reset period 1 -> ticks on even edges.
        rst = 1'b1; run = 1'b1;
        clk();
        chk("run_entry_state", 32'(state), 32'd1);
        chk("run_entry_busy", 32'(busy), 32'd1);
        chk("run_entry_tick", 32'(tick), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            clk();
            chk($sformatf("run_tick_e%0d", k), 32'(tick), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) chk($sformatf("run_tcnt_e%0d", k), 32'(tick_cnt), ecnt(k / 2));
        end
        run = 1'b0;
        clk();
        chk("run_off_state", 32'(state), 32'd0);
        chk("run_off_busy", 32'(busy), 32'd0);
        chk("run_off_tick", 32'(tick), 32'd0);

        // 2: single STEP, period 3, request held 5 cycles -> one tick at edge 4.
        cfg_we = 1'b1; cfg_period = 30'd3;
        clk();
        cfg_we = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            step_req = (i < 5);
            clk();
            chk($sformatf("step_tick_%0d", i), 32'(tick), (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("step_state_%0d", i), 32'(state), (i < 4) ? 32'd2 : 32'd0);
        end
        // Second rising edge during STEP is ignored.
        for (int i = 0; i <= 7; i++) begin
            step_req = (i == 0) || (i == 2);
            clk();
            chk($sformatf("step2_tick_%0d", i), 32'(tick), (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("step2_state_%0d", i), 32'(state), (i < 4) ? 32'd2 : 32'd0);
        end

        // Run and a step edge together in HALT -> RUN, then period change on tick.
        cfg_we = 1'b1; cfg_period = 30'd1;
        clk();
        cfg_we = 1'b0;
        run = 1'b1; step_req = 1'b1;
        clk();
        chk("run_wins_state", 32'(state), 32'd1);
        step_req = 1'b0;
        cfg_period = 30'd4;
        for (int i = 1; i <= 14; i++) begin
            cfg_we = (i == 2);
            clk();
            chk($sformatf("reprog_tick_e%0d", i), 32'(tick),
                (i == 2 || i == 4 || i == 9 || i == 14) ? 32'd1 : 32'd0);
        end
        cfg_we = 1'b0;

        // 4: halt on the counter==period cycle suppresses the tick.
        for (int i = 15; i <= 19; i++) begin
            halt = (i == 19);
            clk();
            chk($sformatf("halt_tick_e%0d", i), 32'(tick), 32'd0);
        end
        chk("halt_state", 32'(state), 32'd0);
        chk("halt_busy", 32'(busy), 32'd0);
        halt = 1'b0; run = 1'b0;
        clk();
        chk("halt_hold_state", 32'(state), 32'd0);

        // 6: reset in the middle of a STEP.
        step_req = 1'b1;
        clk();
        clk();
        clk();
        chk("midstep_state", 32'(state), 32'd2);
        rst = 1'b0; step_req = 1'b0;
        clk();
        chk("rst2_state", 32'(state), 32'd0);
        chk("rst2_tick", 32'(tick), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_tcnt", 32'(tick_cnt), 32'd0);
        rst = 1'b1; run = 1'b1;
        clk();
        chk("rst2_run_state", 32'(state), 32'd1);
        clk();
        chk("rst2_tick_e1", 32'(tick), 32'd0);
        clk();
        chk("rst2_tick_e2", 32'(tick), 32'd1);
        chk("rst2_tcnt_e2", 32'(tick_cnt), ecnt(1));
        run = 1'b0;
        clk();
        chk("rst2_off_state", 32'(state), 32'd0);
        chk("rst2_off_tick", 32'(tick), 32'd0);

        // 5: period 0 -> tick every cycle; tick_cnt wrap.
        cfg_we = 1'b1; cfg_period = 30'd0;
        clk();
        cfg_we = 1'b0; run = 1'b1;
        clk();
        chk("p0_entry_tick", 32'(tick), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            clk();
            chk($sformatf("p0_tick_e%0d", k), 32'(tick), 32'd1);
            chk($sformatf("p0_tcnt_e%0d", k), 32'(tick_cnt), ecnt(1 + k));
        end
`ifdef TICK_CNT_EN
        for (int i = 0; i < 70000 && tick_cnt != 16'hFFFF; i++) clk();
        chk("wrap_ffff", 32'(tick_cnt), 32'h0000_FFFF);
        clk();
        chk("wrap_zero", 32'(tick_cnt), 32'd0);
        chk("wrap_tick", 32'(tick), 32'd1);
`else
        repeat (20) clk();
        chk("nocnt_tcnt", 32'(tick_cnt), 32'd0);
        chk("nocnt_tick", 32'(tick), 32'd1);
`endif
        halt = 1'b1;
        clk();
        chk("final_state", 32'(state), 32'd0);
        chk("final_tick", 32'(tick), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
